// File: rtl/qracc_seq_ctrl.sv
// Sequencer between the CSR block and the QR accelerator array: turns a start
// trigger into one command per (tile, row) and tracks outstanding responses.
module qracc_seq_ctrl #(
  parameter int ADDR_W          = 8,
  parameter int TILE_W          = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              trigger_valid_i,
  input  logic [1:0]        trigger_code_i,
  input  logic [ADDR_W-1:0] cfg_num_rows_i,
  input  logic [TILE_W-1:0] cfg_num_tiles_i,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic              cmd_op_o,
  output logic [ADDR_W-1:0] cmd_row_o,
  output logic [TILE_W-1:0] cmd_tile_o,
  output logic              cmd_last_o,
  input  logic              rsp_valid_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              inst_write_mode_o
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0]     MAX_CNT  = OW'(MAX_OUTSTANDING);
  localparam logic [OW-1:0]     CNT_ONE  = OW'(1);
  localparam logic [ADDR_W-1:0] ROW_ONE  = ADDR_W'(1);
  localparam logic [TILE_W-1:0] TILE_ONE = TILE_W'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        r_code;
  logic [ADDR_W-1:0] r_rows;
  logic [TILE_W-1:0] r_tiles;
  logic [ADDR_W-1:0] r_row;
  logic [TILE_W-1:0] r_tile;
  logic [OW-1:0]     r_outst;
  logic              r_done;
  logic              r_err;

  logic w_issue, w_busy, w_cmd_valid, w_hs, w_row_end, w_tile_end, w_last;
  logic w_rsp_ok, w_rsp_bad, w_code_run, w_trig_go, w_trig_bad, w_cfg_zero;

  assign w_issue     = (r_state == S_ISSUE);
  assign w_busy      = (r_state != S_IDLE);
  assign w_cmd_valid = w_issue && (r_outst < MAX_CNT);
  assign w_hs        = w_cmd_valid && cmd_ready_i;
  assign w_row_end   = (r_row == r_rows - ROW_ONE);
  assign w_tile_end  = (r_tile == r_tiles - TILE_ONE);
  assign w_last      = w_issue && w_row_end && w_tile_end;

  // A response with nothing outstanding is only legal if a command is accepted in the same cycle.
  assign w_rsp_ok    = rsp_valid_i && ((r_outst != '0) || w_hs);
  assign w_rsp_bad   = rsp_valid_i && (r_outst == '0) && !w_hs;

  assign w_code_run  = (trigger_code_i == 2'd1) || (trigger_code_i == 2'd2);
  assign w_trig_go   = trigger_valid_i && !w_busy && w_code_run;
  assign w_trig_bad  = trigger_valid_i && (w_busy || (trigger_code_i == 2'd3));
  assign w_cfg_zero  = (cfg_num_rows_i == '0) || (cfg_num_tiles_i == '0);

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      r_state <= S_IDLE;
      r_code  <= 2'd0;
      r_rows  <= '0;
      r_tiles <= '0;
      r_row   <= '0;
      r_tile  <= '0;
      r_outst <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_hs && !w_rsp_ok)
        r_outst <= r_outst + CNT_ONE;
      else if (!w_hs && w_rsp_ok)
        r_outst <= r_outst - CNT_ONE;

      if (w_rsp_bad || w_trig_bad)
        r_err <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_trig_go) begin
            if (w_cfg_zero) begin
              r_done <= 1'b1;
            end else begin
              r_code  <= trigger_code_i;
              r_rows  <= cfg_num_rows_i;
              r_tiles <= cfg_num_tiles_i;
              r_row   <= '0;
              r_tile  <= '0;
              r_done  <= 1'b0;
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          // Row and tile return to 0 after the final command so idle outputs read 0.
          if (w_hs) begin
            if (w_last) begin
              r_row   <= '0;
              r_tile  <= '0;
              r_state <= S_DRAIN;
            end else if (w_row_end) begin
              r_row  <= '0;
              r_tile <= r_tile + TILE_ONE;
            end else begin
              r_row <= r_row + ROW_ONE;
            end
          end
        end
        S_DRAIN: begin
          if (r_outst == '0) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_valid_o       = w_cmd_valid;
  assign cmd_op_o          = w_issue && (r_code == 2'd2);
  assign cmd_row_o         = r_row;
  assign cmd_tile_o        = r_tile;
  assign cmd_last_o        = w_last;
  assign busy_o            = w_busy;
  assign done_o            = r_done;
  assign err_o             = r_err;
  assign inst_write_mode_o = w_busy && (r_code == 2'd1);

endmodule
